regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file with write-to-read bypass and a per-register
//  busy scoreboard. Sits in decode: supplies rs1/rs2 operands and reports RAW hazards.
//  Issue marks a destination busy; writeback clears it; flush drops all pending marks.
//  Successor to the fixed 32x32 two-read/one-write register file.
// PARAMETERS
//  XLEN       32  data width, bits
//  REG_CNT    32  number of architectural registers; power of 2, >= 2
//  BYPASS_EN  1   1 = same-cycle write data forwarded to reads; 0 = old value returned
//  AW         $clog2(REG_CNT)  address width; localparam, not overridable
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst_n      in   1     synchronous active-low reset
//  rs1        in   AW    read port 1 address
//  rs2        in   AW    read port 2 address
//  rd_data1   out  XLEN  read port 1 data (combinational)
//  rd_data2   out  XLEN  read port 2 data (combinational)
//  rs1_busy   out  1     rs1 has an outstanding producer (combinational)
//  rs2_busy   out  1     rs2 has an outstanding producer (combinational)
//  wr_en      in   1     writeback strobe
//  rd         in   AW    writeback address
//  wr_data    in   XLEN  writeback data
//  issue_en   in   1     instruction with destination issued this cycle
//  issue_rd   in   AW    destination of the issued instruction
//  flush      in   1     pipeline flush: clear every busy bit
//  any_busy   out  1     OR of all busy bits; registered (reflects state after last edge)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all regs <= 0, all busy <= 0. Takes priority over every
//    other input. Mid-operation reset discards in-flight writes and issues.
//  - Register 0 reads 0, is never written, never busy; issue_rd=0 and rd=0 are ignored.
//  - Write: wr_en & rd!=0 -> regs[rd] <= wr_data at edge.
//  - Read: rsN==0 -> 0. Else if BYPASS_EN & wr_en & rd==rsN -> wr_data.
//    Else regs[rsN]. Read latency 0.
//  - rsN_busy = busy[rsN] & ~(wr_en & rd==rsN), i.e. busy is cleared combinationally by
//    a matching writeback in the same cycle. Forced to 0 when BYPASS_EN=0 only if
//    busy[rsN]=0 (no bypass means a matching write still reports busy).
//  - Busy update per register r!=0 at edge, priority high to low:
//      flush                     -> busy[r] <= 0 (issue in the same cycle is dropped)
//      issue_en & issue_rd==r    -> busy[r] <= 1 (wins over same-cycle writeback to r:
//                                   new producer)
//      wr_en & rd==r             -> busy[r] <= 0
//      else                      -> hold
//  - flush does not block the data write; wr_en still updates regs.
//  - Writeback to a non-busy register is legal: data written, busy stays 0.
//  - Issue to an already busy register is legal: busy stays 1 (WAW tracked by pipeline).
//  - any_busy registered: one cycle after the edge that sets or clears the last bit.
//  - Address wrap: none; all AW-bit addresses are valid.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, REG_CNT, REG_AW constants;
//    REG_ZERO = '0 address constant.
//  - One sub-module: regfile_sb_scoreboard (busy vector, flush/issue/write priority,
//    rsN_busy lookup, any_busy register). Data array and bypass muxes stay in top.
// TESTING
//  1 Reset: hold rst_n=0 one edge after writes to x5 -> read x5 = 0, rs1_busy=0,
//    any_busy=0.
//  2 Write/read: wr x7=0xDEADBEEF; next cycle rs1=7 -> 0xDEADBEEF. Write x0=0x1234 ->
//    x0 reads 0.
//  3 Bypass: same cycle wr_en rd=3 data=0xA5A5A5A5 with rs2=3 -> rd_data2=0xA5A5A5A5
//    (BYPASS_EN=1); old value with BYPASS_EN=0.
//  4 Scoreboard: issue x9 -> next cycle rs1=9 busy=1, any_busy=1. Writeback x9 ->
//    rs1_busy=0 same cycle, any_busy=0 after 1 edge.
//  5 Collisions: issue x4 and writeback x4 same edge -> busy[4]=1 after.
//    Flush + issue x6 -> busy[6]=0.
//  6 Param sweep: REG_CNT=16, XLEN=64: write/read all 15 regs with address-as-data
//    pattern, verify readback.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared integer-core constants for the register file and its scoreboard.
// Modules take their own parameters; these are the default widths and sizes.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int REG_CNT = 32;
    localparam int REG_AW  = $clog2(REG_CNT);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage : riscv_pkg

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears, flush drops all.
// Also produces the operand hazard flags and the registered any_busy summary.
module regfile_sb_scoreboard
    import riscv_pkg::*;
#(
    parameter int  REG_CNT   = riscv_pkg::REG_CNT,
    parameter bit  BYPASS_EN = 1'b1,
    localparam int AW        = $clog2(REG_CNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          wr_en,
    input  logic [AW-1:0] rd,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_rd,
    input  logic          flush,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          any_busy
);

    logic [REG_CNT-1:0] busy;
    logic [REG_CNT-1:0] busy_next;
    logic               wb_hit1;
    logic               wb_hit2;

    // Next busy vector: flush beats issue, issue beats a same-cycle writeback.
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < REG_CNT; r++) begin
            if (flush) begin
                busy_next[r] = 1'b0;
            end else if (issue_en && (issue_rd == AW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (wr_en && (rd == AW'(r))) begin
                busy_next[r] = 1'b0;
            end else begin
                busy_next[r] = busy[r];
            end
        end
        busy_next[0] = 1'b0;
    end

    // Busy state and its OR-reduction, both cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            busy     <= busy_next;
            any_busy <= |busy_next;
        end
    end

    // A matching writeback hides the hazard only when its data is forwarded.
    always_comb begin
        wb_hit1  = BYPASS_EN && wr_en && (rd == rs1);
        wb_hit2  = BYPASS_EN && wr_en && (rd == rs2);
        rs1_busy = busy[rs1] && !wb_hit1;
        rs2_busy = busy[rs2] && !wb_hit2;
    end

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and busy scoreboard.
// x0 is hardwired to zero; reads and hazard flags are combinational.
module regfile_sb
    import riscv_pkg::*;
#(
    parameter int  XLEN      = riscv_pkg::XLEN,
    parameter int  REG_CNT   = riscv_pkg::REG_CNT,
    parameter bit  BYPASS_EN = 1'b1,
    localparam int AW        = $clog2(REG_CNT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            any_busy
);

    logic [XLEN-1:0] regs [REG_CNT];
    logic            wr_live;

    assign wr_live = wr_en && (rd != '0);

    // Data array; a write to x0 is dropped so the entry stays zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_CNT; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wr_live) begin
                regs[rd] <= wr_data;
            end else begin
                regs[rd] <= regs[rd];
            end
        end
    end

    // Read port 1: zero register, then forwarded writeback, then array.
    always_comb begin
        if (rs1 == '0) begin
            rd_data1 = '0;
        end else if (BYPASS_EN && wr_en && (rd == rs1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = regs[rs1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        if (rs2 == '0) begin
            rd_data2 = '0;
        end else if (BYPASS_EN && wr_en && (rd == rs2)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = regs[rs2];
        end
    end

    regfile_sb_scoreboard #(
        .REG_CNT   (REG_CNT),
        .BYPASS_EN (BYPASS_EN)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .wr_en    (wr_en),
        .rd       (rd),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .any_busy (any_busy)
    );

endmodule : regfile_sb
